// File: rtl/ram_io_responder.sv
// ram_io_responder: byte-wide memory bus responder serving a RAM plus a console/halt I/O window at 0x30000.
// Latency: one cycle for reads (mem_din registered); writes take effect on the addressing edge.
// Backpressure: io_buffer_full warns the master two slots early; TX drain and RX fill use valid/ready.
// Ports: clk_in/rst_in (sync, active-high), rdy_in bus enable, mem_a/mem_dout/mem_wr/mem_din bus,
//        tx_valid/tx_data/tx_ready console out, rx_valid/rx_data/rx_ready console in,
//        io_buffer_full, tx_overflow, sim_done, sim_code status outputs.

// Small byte FIFO. The caller decides push/pop legality; this block only keeps pointers and count.
// Latency: a pushed byte is visible at the head the cycle after the push (no bypass).
// Backpressure: none internally; count_o/count_d_o let the caller gate pushes and pops.
module ram_io_responder_fifo #(
  parameter int W = 3
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [7:0]   dat_i,
  output logic [7:0]   head_o,
  output logic [W:0]   count_o,
  output logic [W:0]   count_d_o
);
  localparam int DEPTH = 1 << W;
  localparam logic [W-1:0] PTR_ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W:0]   CNT_ONE = {{W{1'b0}}, 1'b1};

  logic [7:0]   mem_q [DEPTH];
  logic [W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    // Simultaneous push and pop leaves the count alone, even when empty.
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; a push during reset is discarded.
  always_ff @(posedge clk_in) begin
    if (!rst_in && push_i) mem_q[wr_ptr_q] <= dat_i;
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign count_d_o = count_d;
endmodule

module ram_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_WIDTH = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_overflow,
  output logic        sim_done,
  output logic [7:0]  sim_code
);
  localparam logic [FIFO_WIDTH:0] DEPTH_C  = (FIFO_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [FIFO_WIDTH:0] FULL_THR = (FIFO_WIDTH+1)'(FIFO_DEPTH - 2);

  logic [7:0] ram_q [0:(1<<ADDR_WIDTH)-1];

  logic [7:0] mem_din_q, mem_din_d;
  logic       io_full_q, tx_ovf_q, sim_done_q;
  logic [7:0] sim_code_q;

  logic [FIFO_WIDTH:0] tx_count, tx_count_d, rx_count, rx_count_d_unused;
  logic [7:0]          tx_head, rx_head;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [2:0]            addr_lo;
  logic io_sel, io_wr_data, io_wr_halt, io_rd_data;
  logic tx_full, tx_push, tx_pop, tx_drop, rx_push, rx_pop, rx_nonempty;
  logic unused_addr_bits;

  assign ram_addr   = mem_a[ADDR_WIDTH-1:0];
  assign addr_lo    = mem_a[2:0];
  assign io_sel     = (mem_a[17:16] == 2'b11);
  assign io_wr_data = rdy_in && io_sel && mem_wr  && (addr_lo == 3'd0);
  assign io_wr_halt = rdy_in && io_sel && mem_wr  && (addr_lo == 3'd4);
  assign io_rd_data = rdy_in && io_sel && !mem_wr && (addr_lo == 3'd0);
  assign unused_addr_bits = &{1'b0, mem_a[31:18]};

  assign tx_full     = (tx_count == DEPTH_C);
  assign tx_valid    = (tx_count != '0);
  assign tx_pop      = tx_valid && tx_ready;
  // A same-cycle drain frees the slot, so a write to a full TX FIFO still lands.
  assign tx_push     = io_wr_data && (!tx_full || tx_pop);
  assign tx_drop     = io_wr_data && tx_full && !tx_pop;

  assign rx_nonempty = (rx_count != '0);
  assign rx_ready    = (rx_count != DEPTH_C);
  assign rx_push     = rx_valid && rx_ready;
  assign rx_pop      = io_rd_data && rx_nonempty;

  ram_io_responder_fifo #(.W(FIFO_WIDTH)) u_tx (
    .clk_in(clk_in), .rst_in(rst_in), .push_i(tx_push), .pop_i(tx_pop), .dat_i(mem_dout),
    .head_o(tx_head), .count_o(tx_count), .count_d_o(tx_count_d)
  );

  ram_io_responder_fifo #(.W(FIFO_WIDTH)) u_rx (
    .clk_in(clk_in), .rst_in(rst_in), .push_i(rx_push), .pop_i(rx_pop), .dat_i(rx_data),
    .head_o(rx_head), .count_o(rx_count), .count_d_o(rx_count_d_unused)
  );

  // Read mux: RAM accesses always return the pre-write byte; I/O writes return zero.
  always_comb begin
    mem_din_d = mem_din_q;
    if (rdy_in) begin
      if (!io_sel) begin
        mem_din_d = ram_q[ram_addr];
      end else if (!mem_wr) begin
        case (addr_lo)
          3'd0:    mem_din_d = rx_nonempty ? rx_head : 8'h00;
          3'd4:    mem_din_d = {6'b0, rx_nonempty, tx_full};
          default: mem_din_d = 8'h00;
        endcase
      end else begin
        mem_din_d = 8'h00;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !io_sel && mem_wr) ram_q[ram_addr] <= mem_dout;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_din_q  <= 8'h00;
      io_full_q  <= 1'b0;
      tx_ovf_q   <= 1'b0;
      sim_done_q <= 1'b0;
      sim_code_q <= 8'h00;
    end else begin
      mem_din_q <= mem_din_d;
      // Two spare slots absorb writes already issued before the master sees the flag.
      io_full_q <= (tx_count_d >= FULL_THR);
      if (tx_drop) tx_ovf_q <= 1'b1;
      if (io_wr_halt) begin
        sim_done_q <= 1'b1;
        sim_code_q <= mem_dout;
      end
    end
  end

  assign mem_din        = mem_din_q;
  assign io_buffer_full = io_full_q;
  assign tx_data        = tx_head;
  assign tx_overflow    = tx_ovf_q;
  assign sim_done       = sim_done_q;
  assign sim_code       = sim_code_q;
endmodule

// File: tb/tb_ram_io_responder.sv
module tb_ram_io_responder;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, mem_wr, tx_ready, rx_valid;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout, rx_data;
  logic [7:0]  mem_din, tx_data, sim_code;
  logic        io_buffer_full, tx_valid, rx_ready, tx_overflow, sim_done;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];

  always #5 clk_in = ~clk_in;

  ram_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .tx_overflow(tx_overflow), .sim_done(sim_done), .sim_code(sim_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; any byte the consumer takes this edge is compared with the TX scoreboard.
  task automatic tick();
    if (tx_valid && tx_ready) begin
      if (tx_q.size() == 0) chk("tx_unexpected_pop", tx_q.size(), 1);
      else chk("tx_data", tx_data, tx_q.pop_front());
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
    mem_a = a; mem_wr = wr; mem_dout = d;
    tick();
    mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00;
  endtask

  task automatic txw(input logic [7:0] d);
    tx_q.push_back(d);
    bus(32'h30000, 1'b1, d);
  endtask

  // Bus access whose mem_din is checked against the scoreboard one cycle later.
  task automatic acc(input string tag, input logic [31:0] a, input logic wr,
                     input logic [7:0] d, input logic [7:0] exp);
    exp_q.push_back(exp);
    bus(a, wr, d);
    chk(tag, mem_din, exp_q.pop_front());
  endtask

  task automatic drain(input string tag);
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && tx_q.size() != 0; i++) tick();
    tx_ready = 1'b0;
    chk(tag, tx_q.size(), 0);
    chk({tag, "_valid"}, tx_valid, 1'b0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_mem_din"}, mem_din, 8'h00);
    chk({tag, "_tx_valid"}, tx_valid, 1'b0);
    chk({tag, "_io_full"}, io_buffer_full, 1'b0);
    chk({tag, "_rx_ready"}, rx_ready, 1'b1);
    chk({tag, "_tx_ovf"}, tx_overflow, 1'b0);
    chk({tag, "_sim_done"}, sim_done, 1'b0);
    chk({tag, "_sim_code"}, sim_code, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; mem_a = 32'h0; mem_dout = 8'h00; mem_wr = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tick(); tick();
    rst_in = 1'b0;
    check_reset("rst0");

    // RAM: write returns old byte, read has one-cycle latency, back-to-back reads.
    bus(32'h1000, 1'b1, 8'h5A);
    acc("ram_wr_old", 32'h1000, 1'b1, 8'hA5, 8'h5A);
    acc("ram_rd", 32'h1000, 1'b0, 8'h00, 8'hA5);
    bus(32'h1001, 1'b1, 8'h3C);
    acc("ram_b2b0", 32'h1000, 1'b0, 8'h00, 8'hA5);
    acc("ram_b2b1", 32'h1001, 1'b0, 8'h00, 8'h3C);

    // TX fill to full, near-full flag, overflow, ordered drain.
    for (int i = 0; i < 8; i++) begin
      txw(8'h41 + 8'(i));
      if (i == 4) chk("io_full_after5", io_buffer_full, 1'b0);
      if (i == 5) chk("io_full_after6", io_buffer_full, 1'b1);
    end
    chk("tx_ovf_before9", tx_overflow, 1'b0);
    bus(32'h30000, 1'b1, 8'h49);
    chk("tx_ovf_after9", tx_overflow, 1'b1);
    acc("status_txfull", 32'h30004, 1'b0, 8'h00, 8'h01);
    drain("tx_drain1");
    chk("io_full_drained", io_buffer_full, 1'b0);

    // RX fill and reads, status bit1 tracking, reserved address.
    rx_valid = 1'b1; rx_data = 8'h31; tick();
    rx_data = 8'h32; tick();
    rx_valid = 1'b0;
    chk("rx_ready", rx_ready, 1'b1);
    acc("io_reserved_rd", 32'h30002, 1'b0, 8'h00, 8'h00);
    acc("status_rx2", 32'h30004, 1'b0, 8'h00, 8'h02);
    acc("rx_rd0", 32'h30000, 1'b0, 8'h00, 8'h31);
    acc("status_rx1", 32'h30004, 1'b0, 8'h00, 8'h02);
    acc("rx_rd1", 32'h30000, 1'b0, 8'h00, 8'h32);
    acc("status_rx0", 32'h30004, 1'b0, 8'h00, 8'h00);
    acc("rx_rd_empty", 32'h30000, 1'b0, 8'h00, 8'h00);

    // Clear the sticky overflow, then push with a same-cycle pop at 7 entries.
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    tx_q.delete();
    chk("tx_ovf_cleared", tx_overflow, 1'b0);
    for (int i = 0; i < 7; i++) txw(8'h50 + 8'(i));
    tx_q.push_back(8'h57);
    mem_a = 32'h30000; mem_wr = 1'b1; mem_dout = 8'h57; tx_ready = 1'b1;
    tick();
    mem_a = 32'h0; mem_wr = 1'b0; tx_ready = 1'b0;
    chk("pushpop_no_ovf", tx_overflow, 1'b0);
    chk("pushpop_io_full", io_buffer_full, 1'b1);
    acc("pushpop_not_full", 32'h30004, 1'b0, 8'h00, 8'h00);
    bus(32'h30001, 1'b1, 8'hEE);
    drain("tx_drain2");

    // rdy_in low freezes the bus side; TX drains and RX fills regardless.
    txw(8'h60); txw(8'h61);
    bus(32'h2000, 1'b1, 8'h77);
    acc("ram_pre_freeze", 32'h2000, 1'b0, 8'h00, 8'h77);
    rdy_in = 1'b0;
    mem_a = 32'h2000; mem_wr = 1'b1; mem_dout = 8'h99;
    tick();
    chk("freeze_mem_din0", mem_din, 8'h77);
    mem_a = 32'h30000; tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 8'h70;
    tick();
    rx_valid = 1'b0;
    tick();
    chk("freeze_tx_drained", tx_q.size(), 0);
    chk("freeze_tx_valid", tx_valid, 1'b0);
    chk("freeze_mem_din1", mem_din, 8'h77);
    mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00; tx_ready = 1'b0;
    rdy_in = 1'b1;
    acc("ram_unchanged", 32'h2000, 1'b0, 8'h00, 8'h77);
    acc("rx_filled_frozen", 32'h30000, 1'b0, 8'h00, 8'h70);

    // Halt register, then a reset cycle carrying a push that must be discarded.
    txw(8'h88);
    rx_valid = 1'b1; rx_data = 8'h11; tick(); rx_valid = 1'b0;
    bus(32'h30004, 1'b1, 8'h00);
    chk("sim_done", sim_done, 1'b1);
    chk("sim_code0", sim_code, 8'h00);
    bus(32'h30004, 1'b1, 8'h5C);
    chk("sim_code1", sim_code, 8'h5C);
    acc("ram_before_rst", 32'h1000, 1'b0, 8'h00, 8'hA5);
    rst_in = 1'b1; mem_a = 32'h30000; mem_wr = 1'b1; mem_dout = 8'h99;
    rx_valid = 1'b1; rx_data = 8'h22;
    tick();
    rst_in = 1'b0; mem_a = 32'h0; mem_wr = 1'b0; rx_valid = 1'b0;
    tx_q.delete();
    check_reset("rst1");
    acc("status_after_rst", 32'h30004, 1'b0, 8'h00, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
